// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Elastic ID/EX pipeline register for the MIPS datapath. It holds a main
// entry, which drives the outputs, and a skid entry. Together they keep one
// entry per cycle flowing when execute stalls, because in_ready is registered.
//
// Ports
//   clock, reset     rising-edge clock, async active-low reset
//   flush            synchronous squash of every held entry
//   in_valid/ready   decode-side handshake (in_ready = !skid valid)
//   in_ctrl/data/regs  entry fields, packed with field 0 in the LSBs
//   out_valid/ready  execute-side handshake
//   out_ctrl         main control bits, zeroed while out_valid=0
//   out_data/regs    main entry fields
//   stall_cnt        saturating count of cycles with in_valid & !in_ready
//
// State is implied by the valid bits:
//   state | meaning
//   EMPTY | main=0 skid=0
//   ONE   | main=1 skid=0
//   TWO   | main=1 skid=1, in_ready=0
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int CTRL_W   = 9,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 4,
  parameter int REG_W    = 5,
  parameter int NUM_REG  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  input  logic [NUM_REG*REG_W-1:0]     in_regs,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0]   out_data,
  output logic [NUM_REG*REG_W-1:0]     out_regs,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int DW = NUM_DATA*DATA_W;
  localparam int RW = NUM_REG*REG_W;

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DW-1:0]     main_data_q,  main_data_d;
  logic [RW-1:0]     main_regs_q,  main_regs_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DW-1:0]     skid_data_q,  skid_data_d;
  logic [RW-1:0]     skid_regs_q,  skid_regs_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  logic accept;
  logic release_main;

  assign in_ready     = ~skid_valid_q;
  assign accept       = in_valid & in_ready;
  assign release_main = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    main_regs_d  = main_regs_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    skid_regs_d  = skid_regs_q;

    if (flush) begin
      // Fields are left stale; only the valids drop. Any input this cycle is dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (release_main) begin
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        main_regs_d  = skid_regs_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (release_main && accept) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
        main_regs_d = in_regs;
      end else if (release_main) begin
        main_valid_d = 1'b0;
      end else if (accept) begin
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
        skid_regs_d  = in_regs;
        skid_valid_d = 1'b1;
      end
    end else if (accept) begin
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
      main_regs_d  = in_regs;
      main_valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      main_regs_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_regs_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      main_regs_q  <= main_regs_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_regs_q  <= skid_regs_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign out_regs  = main_regs_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   in_ctrl;
  logic [127:0] in_data;
  logic [9:0]   in_regs;
  logic         out_valid;
  logic         out_ready;
  logic [8:0]   out_ctrl;
  logic [127:0] out_data;
  logic [9:0]   out_regs;
  logic [15:0]  stall_cnt;

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  logic         s_in_ready, s_out_valid;
  logic [8:0]   s_out_ctrl;
  logic [127:0] s_out_data;
  logic [9:0]   s_out_regs;
  logic [3:0]   s_stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  id_ex_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_regs(out_regs),
    .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .out_regs(s_out_regs),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] mk_data(input logic [7:0] x);
    return {24'h0, x, 24'h100, x, 24'h200, x, 24'h300, x};
  endfunction

  task automatic drive(input logic v, input logic [8:0] c, input logic [127:0] d, input logic [9:0] r);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    in_regs  = r;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #12;
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready, 1'b1);
    check("rst_out_ctrl",  out_ctrl, 9'h0);
    check("rst_out_data",  out_data, 128'h0);
    check("rst_out_regs",  out_regs, 10'h0);
    check("rst_stall_cnt", stall_cnt, 16'h0);
    reset = 1'b1;
    @(negedge clock);

    // Basic flow
    drive(1'b1, 9'h1A5, {32'h0000_0010, 32'h1234_5678, 32'hDEADBEEF, 32'h0040_0004}, {5'd3, 5'd7});
    step();
    drive(1'b0, '0, '0, '0);
    check("flow_valid", out_valid, 1'b1);
    check("flow_ctrl",  out_ctrl, 9'h1A5);
    check("flow_data",  out_data, {32'h0000_0010, 32'h1234_5678, 32'hDEADBEEF, 32'h0040_0004});
    check("flow_regs",  out_regs, 10'b00011_00111);
    check("flow_ready", in_ready, 1'b1);
    step();
    check("flow_drain", out_valid, 1'b0);

    // Stall and skid: A, B, then C held
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 9'h011, mk_data(8'hA1), 10'h011);
    step();
    check("skid_a_valid", out_valid, 1'b1);
    check("skid_a_ready", in_ready, 1'b1);
    drive(1'b1, 9'h022, mk_data(8'hB2), 10'h022);
    step();
    check("skid_b_ready", in_ready, 1'b0);
    check("skid_b_out_a", out_ctrl, 9'h011);
    drive(1'b1, 9'h033, mk_data(8'hC3), 10'h033);
    step(); step(); step();
    check("stall_cnt_3",  stall_cnt, 16'd3);
    check("hold_a_ctrl",  out_ctrl, 9'h011);
    check("hold_a_data",  out_data, mk_data(8'hA1));
    check("hold_a_regs",  out_regs, 10'h011);
    out_ready = 1'b1;
    step();
    check("rel_b_ctrl", out_ctrl, 9'h022);
    check("rel_b_data", out_data, mk_data(8'hB2));
    check("rel_b_ready", in_ready, 1'b1);
    check("stall_cnt_4", stall_cnt, 16'd4);
    step();
    drive(1'b0, '0, '0, '0);
    check("rel_c_ctrl", out_ctrl, 9'h033);
    check("rel_c_data", out_data, mk_data(8'hC3));
    check("rel_c_regs", out_regs, 10'h033);
    step();
    check("rel_empty", out_valid, 1'b0);

    // Flush while in TWO with D presented
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 9'h044, mk_data(8'hE4), 10'h044); step();
    drive(1'b1, 9'h055, mk_data(8'hF5), 10'h055); step();
    check("flush_pre_two", in_ready, 1'b0);
    flush = 1'b1;
    drive(1'b1, 9'h066, mk_data(8'hD6), 10'h066);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ctrl",  out_ctrl, 9'h0);
    check("flush_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    check("flush_no_d_1", out_valid, 1'b0);
    step();
    check("flush_no_d_2", out_valid, 1'b0);

    // Flush in ONE with a release in the same cycle, then accept resumes
    drive(1'b1, 9'h077, mk_data(8'h77), 10'h077); step();
    flush = 1'b1; drive(1'b1, 9'h088, mk_data(8'h88), 10'h088); step();
    flush = 1'b0; drive(1'b1, 9'h099, mk_data(8'h99), 10'h099); step();
    check("flush1_next_ctrl", out_ctrl, 9'h099);
    drive(1'b0, '0, '0, '0); step();

    // Back-to-back stream
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 9'(i + 1), {96'h0, 32'(32'h0040_0000 + i*4)}, 10'(i));
      step();
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_npc",   out_data[31:0], 32'(32'h0040_0000 + i*4));
      check("b2b_ctrl",  out_ctrl, 9'(i + 1));
    end
    drive(1'b0, '0, '0, '0);
    step();
    check("b2b_end", out_valid, 1'b0);
    check("b2b_no_stall", stall_cnt, 16'd0);

    // Saturation: narrow counter saturates, wide one keeps counting
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 9'h101, mk_data(8'h11), 10'h101); step();
    drive(1'b1, 9'h102, mk_data(8'h22), 10'h102); step();
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt_15",  s_stall_cnt, 4'd15);
    check("wide_cnt_20", stall_cnt, 16'd20);
    step();
    check("sat_cnt_hold", s_stall_cnt, 4'd15);
    check("wide_cnt_21",  stall_cnt, 16'd21);

    // Async reset between edges while in TWO
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    check("arst_ctrl",  out_ctrl, 9'h0);
    check("arst_data",  out_data, 128'h0);
    check("arst_regs",  out_regs, 10'h0);
    check("arst_cnt",   stall_cnt, 16'd0);
    check("arst_scnt",  s_stall_cnt, 4'd0);
    drive(1'b0, '0, '0, '0);
    #10;
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    check("arst_after", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
